nist_multi_test_monitor: RTL and testbench
==========================================

NIST_MULTI_TEST_MONITOR -- requirements
Module: nist_multi_test_monitor

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- LOG2_N, 10, window length N = 2^LOG2_N bits.
- MONO_THR, 64, monobit fail when |2*ones - N| > MONO_THR.
- BLK_LOG2, 5, block length M = 2^BLK_LOG2; BLK_LOG2 < LOG2_N.
- BLK_THR, 8, block is bad when |2*ones_blk - M| > BLK_THR.
- BLK_MAX, 4, block-frequency fail when bad blocks > BLK_MAX.
- RUN_MAX, 20, runs fail when the longest run of identical bits > RUN_MAX.
- FCNT_W, 8, fail counter width.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, single clock, rising edge.
- rstn, in, 1, asynchronous active-low reset.
- RND_in, in, 1, random bit under test.
- en, in, 1, run enable.
- test_mask, in, 3, bit i=1 enables test i: 0 monobit, 1 block frequency, 2 runs.
- clr_err, in, 1, clears sticky errors and the fail counter.
- error, out, 3, sticky per-test failure flags, same bit order as test_mask.
- err_any, out, 1, OR of error.
- done, out, 1, one-cycle pulse per completed window.
- fail_cnt, out, FCNT_W, count of windows with at least one enabled failure, saturating.

Function
REQ-003 FSM SHALL have states IDLE, RUN, EVAL; reset state IDLE.
REQ-004 IDLE -> RUN on a clk edge with en=1; all window accumulators clear on entry.
REQ-005 In RUN, RND_in SHALL be sampled on every rising edge, N samples per window, bit index 0..N-1.
REQ-006 After sample N-1, RUN -> EVAL; EVAL lasts exactly 1 cycle and ignores RND_in.
REQ-007 EVAL -> RUN with cleared accumulators if en=1, else EVAL -> IDLE.
REQ-008 en=0 during RUN SHALL abort the window: return to IDLE, discard all accumulators, no done pulse, no error or fail_cnt update.
REQ-009 en=0 during EVAL SHALL NOT abort; the verdict still completes.
REQ-010 Ones counter width LOG2_N+1; monobit statistic computed signed on LOG2_N+2 bits, absolute value compared.
REQ-011 Block ones counter width BLK_LOG2+1, evaluated and cleared after every M-th bit; bad-block counter saturates at BLK_MAX+1.
REQ-012 Run length: bit 0 starts a run of 1; equal successive bit increments, a different bit resets to 1; saturates at RUN_MAX+1; the sticky run-exceeded flag sets on reaching RUN_MAX+1.
REQ-013 At the end of EVAL, each error[i] SHALL be set if test i failed and test_mask[i]=1; masked tests never set error.
REQ-014 The error bits SHALL be sticky until clr_err or reset.
REQ-015 fail_cnt SHALL increment by 1 at the end of EVAL if any enabled test failed, and saturate at 2^FCNT_W-1.
REQ-016 done SHALL be high for exactly the cycle following EVAL, coincident with the updated error and fail_cnt.
REQ-017 clr_err SHALL clear error and fail_cnt at the next edge.
REQ-018 If clr_err coincides with a failing EVAL, the clear applies first, then the new failure: error equals the new failing set and fail_cnt=1.
REQ-019 test_mask is sampled during EVAL only; changes mid-window have no effect until the next EVAL.
REQ-020 err_any is combinational OR of the registered error bits.

Reset
REQ-021 rstn=0 SHALL immediately force IDLE, error=0, err_any=0, done=0, fail_cnt=0, and clear all accumulators, including mid-window and mid-EVAL.
REQ-022 After rstn deasserts, the first window starts on the first edge with en=1.

Verification (LOG2_N=4, MONO_THR=4, BLK_LOG2=2, BLK_THR=2, BLK_MAX=1, RUN_MAX=5, FCNT_W=8)
REQ-023 Reset asserted mid-window -> all outputs 0 the same cycle; no done pulse follows.
REQ-024 en=1, mask=111, 16 bits of 0101... -> EVAL then done pulse; error=000, fail_cnt=0.
REQ-025 en=1, mask=111, 16 ones -> done pulse; error=111, err_any=1, fail_cnt=1.
REQ-026 en=1, mask=110, 16 ones -> error=110, fail_cnt=1.
REQ-027 en dropped after 10 bits, then re-raised with 16 ones -> exactly one done pulse, at 16 samples plus EVAL after re-enable; fail_cnt=1.
REQ-028 With error=111 and fail_cnt=5, clr_err pulsed during a failing EVAL with mask=001 and 16 ones -> error=001, fail_cnt=1.
REQ-029 256 consecutive failing windows -> fail_cnt=255 and holds at 255.

Source files
------------

// File: rtl/nist_multi_test_monitor.sv
// Online randomness monitor running three NIST-style tests (monobit, block
// frequency, longest run) over consecutive windows of N = 2^LOG2_N bits.
// Each completed window gets a one-cycle verdict (EVAL), which updates the sticky
// per-test error flags and a saturating count of failing windows.
//
// Handshake: there is no valid/ready pair. While 'en' is high in RUN, one RND_in
// bit is consumed on every rising edge. 'done' pulses for exactly one cycle after
// each verdict, and the error and fail_cnt outputs are updated in that same cycle.
module nist_multi_test_monitor #(
  parameter int LOG2_N   = 10,
  parameter int MONO_THR = 64,
  parameter int BLK_LOG2 = 5,
  parameter int BLK_THR  = 8,
  parameter int BLK_MAX  = 4,
  parameter int RUN_MAX  = 20,
  parameter int FCNT_W   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              RND_in,
  input  logic              en,
  input  logic [2:0]        test_mask,
  input  logic              clr_err,
  output logic [2:0]        error,
  output logic              err_any,
  output logic              done,
  output logic [FCNT_W-1:0] fail_cnt
);

  localparam int BAD_W = $clog2(BLK_MAX + 2);
  localparam int RUN_W = $clog2(RUN_MAX + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_EVAL = 2'd2;

  // N and M expressed at the width of their doubled-count statistics
  localparam logic [LOG2_N+1:0]   N_VAL    = {2'b01, {LOG2_N{1'b0}}};
  localparam logic [BLK_LOG2+1:0] M_VAL    = {2'b01, {BLK_LOG2{1'b0}}};
  localparam logic [BAD_W-1:0]    BAD_SAT  = BAD_W'(BLK_MAX + 1);
  localparam logic [RUN_W-1:0]    RUN_SAT  = RUN_W'(RUN_MAX + 1);
  localparam logic [RUN_W-1:0]    RUN_ONE  = RUN_W'(1);
  localparam logic [FCNT_W-1:0]   FCNT_MAX = {FCNT_W{1'b1}};

  logic [1:0]          state_q, state_d;
  logic [LOG2_N-1:0]   bit_cnt_q, bit_cnt_d;
  logic [LOG2_N:0]     ones_q, ones_d;
  logic [BLK_LOG2:0]   blk_ones_q, blk_ones_d;
  logic [BAD_W-1:0]    bad_q, bad_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic                prev_q, prev_d;
  logic                run_fail_q, run_fail_d;
  logic [2:0]          error_q, error_d;
  logic [FCNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic                done_q, done_d;

  logic [BLK_LOG2:0]   blk_sum;
  logic [BLK_LOG2+1:0] blk_diff, blk_abs;
  logic                blk_bad;
  logic [LOG2_N+1:0]   mono_diff, mono_abs;
  logic                mono_fail, blk_fail;
  logic [2:0]          fail_vec;

  // Block statistic includes the bit arriving this cycle; |2*ones - M| via two's complement
  always_comb begin
    blk_sum  = blk_ones_q + {{BLK_LOG2{1'b0}}, RND_in};
    blk_diff = {blk_sum, 1'b0} - M_VAL;
    blk_abs  = blk_diff[BLK_LOG2+1] ? (~blk_diff + 1'b1) : blk_diff;
    blk_bad  = 32'(blk_abs) > 32'(BLK_THR);
  end

  // Window verdict; the true range [-N, N] of 2*ones - N fits the signed LOG2_N+2 bits
  always_comb begin
    mono_diff = {ones_q, 1'b0} - N_VAL;
    mono_abs  = mono_diff[LOG2_N+1] ? (~mono_diff + 1'b1) : mono_diff;
    mono_fail = 32'(mono_abs) > 32'(MONO_THR);
    blk_fail  = 32'(bad_q) > 32'(BLK_MAX);
    fail_vec  = test_mask & {run_fail_q, blk_fail, mono_fail};
  end

  // Next-state logic: sequencing, accumulators and verdict bookkeeping
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ones_d     = ones_q;
    blk_ones_d = blk_ones_q;
    bad_d      = bad_q;
    run_d      = run_q;
    prev_d     = prev_q;
    run_fail_d = run_fail_q;
    done_d     = 1'b0;
    // Clear acts first so a coincident failing verdict lands on a clean slate
    error_d    = clr_err ? 3'b000 : error_q;
    fail_cnt_d = clr_err ? '0 : fail_cnt_q;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d  = '0;
        ones_d     = '0;
        blk_ones_d = '0;
        bad_d      = '0;
        run_d      = '0;
        prev_d     = 1'b0;
        run_fail_d = 1'b0;
        if (en) state_d = S_RUN;
      end

      S_RUN: begin
        if (!en) begin
          // Aborted window: drop everything collected so far
          state_d    = S_IDLE;
          bit_cnt_d  = '0;
          ones_d     = '0;
          blk_ones_d = '0;
          bad_d      = '0;
          run_d      = '0;
          prev_d     = 1'b0;
          run_fail_d = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          ones_d    = ones_q + {{LOG2_N{1'b0}}, RND_in};
          prev_d    = RND_in;

          if (&bit_cnt_q[BLK_LOG2-1:0]) begin
            blk_ones_d = '0;
            if (blk_bad && (bad_q != BAD_SAT)) bad_d = bad_q + 1'b1;
          end else begin
            blk_ones_d = blk_sum;
          end

          if ((bit_cnt_q == '0) || (RND_in != prev_q)) begin
            run_d = RUN_ONE;
          end else if (run_q != RUN_SAT) begin
            run_d = run_q + 1'b1;
          end
          if (run_d == RUN_SAT) run_fail_d = 1'b1;

          if (&bit_cnt_q) state_d = S_EVAL;
        end
      end

      S_EVAL: begin
        done_d  = 1'b1;
        error_d = error_d | fail_vec;
        if ((|fail_vec) && (fail_cnt_d != FCNT_MAX)) fail_cnt_d = fail_cnt_d + 1'b1;
        bit_cnt_d  = '0;
        ones_d     = '0;
        blk_ones_d = '0;
        bad_d      = '0;
        run_d      = '0;
        prev_d     = 1'b0;
        run_fail_d = 1'b0;
        state_d    = en ? S_RUN : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and accumulator registers with asynchronous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      ones_q     <= '0;
      blk_ones_q <= '0;
      bad_q      <= '0;
      run_q      <= '0;
      prev_q     <= 1'b0;
      run_fail_q <= 1'b0;
      error_q    <= 3'b000;
      fail_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_q     <= ones_d;
      blk_ones_q <= blk_ones_d;
      bad_q      <= bad_d;
      run_q      <= run_d;
      prev_q     <= prev_d;
      run_fail_q <= run_fail_d;
      error_q    <= error_d;
      fail_cnt_q <= fail_cnt_d;
      done_q     <= done_d;
    end
  end

  assign error    = error_q;
  assign err_any  = |error_q;
  assign done     = done_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_nist_multi_test_monitor.sv
// Bench for nist_multi_test_monitor with a small window (N=16, M=4). A window-level
// model collects each window's bits and judges the window with plain
// arithmetic. The DUT outputs are compared against this model on every falling
// edge. Directed scenarios also pin the expected values with literals.
module tb_nist_multi_test_monitor;

  localparam int N        = 16;
  localparam int M        = 4;
  localparam int MONO_THR = 4;
  localparam int BLK_THR  = 2;
  localparam int BLK_MAX  = 1;
  localparam int RUN_MAX  = 5;

  // clock / reset and DUT signals
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       RND_in = 1'b0;
  logic       en = 1'b0;
  logic       clr_err = 1'b0;
  logic [2:0] test_mask = 3'b000;
  logic [2:0] error;
  logic       err_any;
  logic       done;
  logic [7:0] fail_cnt;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int d0;

  always #5 clk = ~clk;

  nist_multi_test_monitor #(
    .LOG2_N(4), .MONO_THR(MONO_THR), .BLK_LOG2(2), .BLK_THR(BLK_THR),
    .BLK_MAX(BLK_MAX), .RUN_MAX(RUN_MAX), .FCNT_W(8)
  ) dut (
    .clk(clk), .rstn(rstn), .RND_in(RND_in), .en(en), .test_mask(test_mask),
    .clr_err(clr_err), .error(error), .err_any(err_any), .done(done),
    .fail_cnt(fail_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- window-level model ----------------
  int         pos = -1;        // -1 waiting for en, 0..N-1 bits collected, N verdict due
  bit         win_bits[$];
  logic [2:0] m_err = 3'b000;
  int         m_fcnt = 0;
  bit         m_done = 1'b0;

  function automatic logic [2:0] verdict();
    int ones, bad, o, run, longest;
    logic [2:0] v;
    ones = 0;
    foreach (win_bits[i]) ones += int'(win_bits[i]);
    v[0] = ((2 * ones - N) > MONO_THR) || ((N - 2 * ones) > MONO_THR);
    bad = 0;
    for (int b = 0; b < N / M; b++) begin
      o = 0;
      for (int k = 0; k < M; k++) o += int'(win_bits[M * b + k]);
      if (((2 * o - M) > BLK_THR) || ((M - 2 * o) > BLK_THR)) bad++;
    end
    v[1] = bad > BLK_MAX;
    longest = 0;
    run = 0;
    for (int i = 0; i < N; i++) begin
      if (i > 0 && win_bits[i] == win_bits[i - 1]) run++;
      else run = 1;
      if (run > longest) longest = run;
    end
    v[2] = longest > RUN_MAX;
    return v;
  endfunction

  task automatic model_step();
    logic [2:0] f;
    if (!rstn) begin
      pos = -1;
      win_bits.delete();
      m_err = 3'b000;
      m_fcnt = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (pos == N) begin
        f = verdict() & test_mask;
        if (clr_err) begin
          m_err = f;
          m_fcnt = (f != 3'b000) ? 1 : 0;
        end else begin
          m_err = m_err | f;
          if (f != 3'b000 && m_fcnt < 255) m_fcnt++;
        end
        m_done = 1'b1;
        win_bits.delete();
        pos = en ? 0 : -1;
      end else begin
        if (clr_err) begin
          m_err = 3'b000;
          m_fcnt = 0;
        end
        if (pos == -1) begin
          if (en) pos = 0;
        end else if (!en) begin
          pos = -1;
          win_bits.delete();
        end else begin
          win_bits.push_back(RND_in);
          pos++;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    check("error", 32'(error), 32'(m_err));
    check("err_any", 32'(err_any), 32'(|m_err));
    check("done", 32'(done), 32'(m_done));
    check("fail_cnt", 32'(fail_cnt), 32'(m_fcnt[7:0]));
    if (done === 1'b1) done_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_pulse();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  // Drive one window; returns on the falling edge where done should be high
  task automatic window(input logic [15:0] bits, input logic [2:0] run_mask,
                        input logic [2:0] eval_mask, input bit from_idle,
                        input bit stay, input bit clr_at_eval);
    test_mask = run_mask;
    if (from_idle) begin
      en = 1'b1;
      tick();
    end
    for (int i = 0; i < N; i++) begin
      RND_in = bits[i];
      tick();
    end
    test_mask = eval_mask;
    en = stay;
    clr_err = clr_at_eval;
    RND_in = ~RND_in;
    tick();
    clr_err = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rstn = 1'b0;
    repeat (2) tick();
    check("rst_error", 32'(error), 32'h0);
    check("rst_err_any", 32'(err_any), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_fail_cnt", 32'(fail_cnt), 32'h0);
    rstn = 1'b1;
    tick();

    // alternating bits pass every test
    window(16'hAAAA, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0);
    check("alt_done", 32'(done), 32'h1);
    check("alt_error", 32'(error), 32'h0);
    check("alt_fail_cnt", 32'(fail_cnt), 32'h0);

    // all ones fail every test
    window(16'hFFFF, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0);
    check("ones_done", 32'(done), 32'h1);
    check("ones_error", 32'(error), 32'h7);
    check("ones_err_any", 32'(err_any), 32'h1);
    check("ones_fail_cnt", 32'(fail_cnt), 32'h1);
    tick();
    check("done_single_pulse", 32'(done), 32'h0);

    clear_pulse();
    check("clr_error", 32'(error), 32'h0);
    check("clr_fail_cnt", 32'(fail_cnt), 32'h0);

    // monobit masked off
    window(16'hFFFF, 3'b110, 3'b110, 1'b1, 1'b0, 1'b0);
    check("mask110_error", 32'(error), 32'h6);
    check("mask110_fail_cnt", 32'(fail_cnt), 32'h1);

    // runs-only failure (run of six ones)
    clear_pulse();
    window(16'h257E, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0);
    check("run_only_error", 32'(error), 32'h4);

    // block-frequency-only failure (two unbalanced blocks)
    clear_pulse();
    window(16'hAA0F, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0);
    check("blk_only_error", 32'(error), 32'h2);

    // monobit-only failure; mask is zero mid-window, only the verdict-time mask counts
    clear_pulse();
    window(16'hB777, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0);
    check("mono_only_error", 32'(error), 32'h1);
    check("mono_only_fail_cnt", 32'(fail_cnt), 32'h1);

    // aborted window after 10 bits, then a full failing window
    clear_pulse();
    d0 = done_seen;
    en = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      RND_in = 1'b1;
      tick();
    end
    en = 1'b0;
    repeat (4) tick();
    check("abort_no_done", 32'(done_seen - d0), 32'h0);
    check("abort_fail_cnt", 32'(fail_cnt), 32'h0);
    window(16'hFFFF, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0);
    check("reenable_done", 32'(done), 32'h1);
    check("reenable_done_count", 32'(done_seen - d0), 32'h1);
    check("reenable_fail_cnt", 32'(fail_cnt), 32'h1);

    // clear coinciding with a failing verdict
    clear_pulse();
    for (int w = 0; w < 5; w++) window(16'hFFFF, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0);
    check("pre_clr_error", 32'(error), 32'h7);
    check("pre_clr_fail_cnt", 32'(fail_cnt), 32'h5);
    window(16'hFFFF, 3'b001, 3'b001, 1'b1, 1'b0, 1'b1);
    check("clr_eval_error", 32'(error), 32'h1);
    check("clr_eval_fail_cnt", 32'(fail_cnt), 32'h1);

    // reset in the middle of a window
    en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      RND_in = 1'b1;
      tick();
    end
    #2 rstn = 1'b0;
    #1;
    check("midrst_error", 32'(error), 32'h0);
    check("midrst_err_any", 32'(err_any), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_fail_cnt", 32'(fail_cnt), 32'h0);
    en = 1'b0;
    d0 = done_seen;
    repeat (3) tick();
    rstn = 1'b1;
    repeat (20) tick();
    check("midrst_no_done", 32'(done_seen - d0), 32'h0);
    window(16'hAAAA, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0);
    check("post_rst_done", 32'(done), 32'h1);
    check("post_rst_error", 32'(error), 32'h0);

    // back-to-back failing windows saturate the counter
    clear_pulse();
    for (int w = 0; w < 258; w++) begin
      window(16'hFFFF, 3'b111, 3'b111, (w == 0), (w != 257), 1'b0);
      if (w == 254) check("sat_reach_255", 32'(fail_cnt), 32'hFF);
    end
    check("sat_hold_255", 32'(fail_cnt), 32'hFF);
    check("sat_error", 32'(error), 32'h7);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
